friet_lwc_stream_arbiter: RTL and testbench
===========================================

Name: friet_lwc_stream_arbiter

Overview:
- Merges the two LWC input streams, public data (PDI) and secret key (SDI), into one registered output stream for the FRIET core input path.
- Arbitrates round-robin at segment granularity: once a source is granted, the grant holds until that source transfers a word with last=1.
- The output stage is a single-entry registered buffer. Each word is tagged with its source and its last flag.

Parameters:
- G_WIDTH, 32, data width of PDI, SDI and output words.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- pdi_data  in  G_WIDTH  public data word.
- pdi_last  in  1  marks final word of the current PDI segment.
- pdi_valid  in  1  PDI word valid.
- pdi_ready  out  1  PDI word accepted this cycle when pdi_valid=1.
- sdi_data  in  G_WIDTH  secret key word.
- sdi_last  in  1  marks final word of the current SDI segment.
- sdi_valid  in  1  SDI word valid.
- sdi_ready  out  1  SDI word accepted this cycle when sdi_valid=1.
- dout  out  G_WIDTH  buffered output word.
- dout_last  out  1  last flag of the buffered word.
- dout_src  out  1  source of the buffered word: 0=PDI, 1=SDI.
- dout_valid  out  1  output buffer holds a word.
- dout_ready  in  1  downstream accepts the word.
- busy  out  1  a segment grant is active (state not IDLE).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high. All registers clear immediately on rst=1, without waiting for a clock edge.
- Reset values:
  - state=IDLE, last_src=0 (PDI), buffer empty.
  - dout_valid=0, dout_last=0, dout_src=0, dout=0.
  - pdi_ready=0, sdi_ready=0, busy=0.
- FSM states: IDLE, GNT_PDI, GNT_SDI.
- IDLE transitions:
  - If only pdi_valid=1, go to GNT_PDI.
  - If only sdi_valid=1, go to GNT_SDI.
  - If both are valid, grant the source that is not last_src (tie goes to the other source).
  - If neither is valid, stay in IDLE.
  - No word transfers in the IDLE cycle. Both readies are 0 in IDLE.
- Grant states:
  - Only the granted source's ready may be 1. The other source's ready is 0.
  - ready = buffer empty OR dout_ready, i.e. accept when the buffer is empty or is being drained this cycle.
  - A transfer occurs when valid & ready are both 1. On transfer, the buffer loads {data, last, src} and becomes or stays full.
  - A transfer with last=1 moves the FSM to IDLE and sets last_src to the granted source.
  - A transfer with last=0, or no transfer, holds the grant.
- Output buffer:
  - dout_valid = buffer full.
  - Output drain occurs when dout_valid & dout_ready.
  - Drain without load: buffer becomes empty.
  - Simultaneous load and drain: buffer stays full with the new word.
  - Neither load nor drain: contents hold.
  - dout, dout_last and dout_src are driven only from registers, never combinationally from the inputs.
- Latency:
  - From the first valid in IDLE to the first accepted word: 1 cycle (grant cycle).
  - From accept to dout_valid: 1 cycle.
  - Sustained throughput within a segment: 1 word/cycle while dout_ready=1.
  - Between segments: 1 bubble cycle for the IDLE re-arbitration.
- Boundaries:
  - Buffer full and dout_ready=0: the granted source's ready is 0; the source stalls, no drop, no overwrite.
  - A single-word segment (last=1 on the first word) is legal: grant for one transfer, then back to IDLE.
  - The non-granted source may hold valid=1 indefinitely during a segment and is never accepted until the segment ends.
  - Reset mid-segment clears the grant and the buffer. A word held in the buffer is discarded, and sources restart arbitration after reset deasserts.
  - Data and last inputs are sampled only on a transfer. Values on non-granted inputs are don't-care.

Test Plan:
- Reset then pdi_valid=1 with a 3-word segment A1,A2,A3 (last on A3), dout_ready=1 -> grant next cycle. Output shows A1..A3 with src=0 on consecutive cycles, dout_last=1 on A3 only, then busy=0.
- Both valid after reset (last_src=PDI), SDI 2-word segment K1,K2 and PDI 1-word segment P1 -> SDI granted first. Output order K1,K2,P1 with src 1,1,0, and one IDLE bubble between K2 and P1.
- Granted PDI, buffer full, dout_ready=0 for 4 cycles -> pdi_ready=0 for those cycles, dout holds the same word and valid. When dout_ready rises, the next word loads in the same cycle as the drain, with no loss.
- PDI segment in progress and sdi_valid asserted mid-segment -> sdi_ready stays 0 until the PDI last word is accepted. The SDI grant follows after one IDLE cycle.
- Assert rst asynchronously mid-segment with the buffer full -> dout_valid=0, both readies=0, busy=0 before the next clk edge. After release, the first arbitration picks SDI on a tie.

Source files
------------

// File: rtl/friet_lwc_stream_arbiter.sv
// Round-robin merge of the LWC PDI and SDI streams into one registered output word
// stream. A grant is held per segment and released on the word carrying last=1.
module friet_lwc_stream_arbiter #(
  parameter int G_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [G_WIDTH-1:0] i_pdi_data,
  input  logic               i_pdi_last,
  input  logic               i_pdi_valid,
  output logic               o_pdi_ready,
  input  logic [G_WIDTH-1:0] i_sdi_data,
  input  logic               i_sdi_last,
  input  logic               i_sdi_valid,
  output logic               o_sdi_ready,
  output logic [G_WIDTH-1:0] o_dout,
  output logic               o_dout_last,
  output logic               o_dout_src,
  output logic               o_dout_valid,
  input  logic               i_dout_ready,
  output logic               o_busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GNT_PDI = 2'd1,
    S_GNT_SDI = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_last_src;
  logic                 r_full;
  logic [G_WIDTH-1:0]   r_dout;
  logic                 r_dout_last;
  logic                 r_dout_src;

  logic                 w_can_accept;
  logic                 w_pdi_ready;
  logic                 w_sdi_ready;
  logic                 w_pdi_xfer;
  logic                 w_sdi_xfer;
  logic                 w_load;
  logic                 w_drain;
  logic [G_WIDTH-1:0]   w_load_data;
  logic                 w_load_last;

  // The buffer can take a word when empty or when its current word leaves this cycle.
  assign w_can_accept = ~r_full | i_dout_ready;
  assign w_pdi_ready  = (r_state == S_GNT_PDI) & w_can_accept;
  assign w_sdi_ready  = (r_state == S_GNT_SDI) & w_can_accept;
  assign w_pdi_xfer   = i_pdi_valid & w_pdi_ready;
  assign w_sdi_xfer   = i_sdi_valid & w_sdi_ready;
  assign w_load       = w_pdi_xfer | w_sdi_xfer;
  assign w_drain      = r_full & i_dout_ready;
  assign w_load_data  = w_sdi_xfer ? i_sdi_data : i_pdi_data;
  assign w_load_last  = w_sdi_xfer ? i_sdi_last : i_pdi_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_last_src  <= 1'b0;
      r_full      <= 1'b0;
      r_dout      <= '0;
      r_dout_last <= 1'b0;
      r_dout_src  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          // On a tie the source that did not own the previous segment wins.
          if (i_pdi_valid && i_sdi_valid) begin
            r_state <= r_last_src ? S_GNT_PDI : S_GNT_SDI;
          end else if (i_pdi_valid) begin
            r_state <= S_GNT_PDI;
          end else if (i_sdi_valid) begin
            r_state <= S_GNT_SDI;
          end
        end
        S_GNT_PDI: begin
          if (w_pdi_xfer && i_pdi_last) begin
            r_state    <= S_IDLE;
            r_last_src <= 1'b0;
          end
        end
        S_GNT_SDI: begin
          if (w_sdi_xfer && i_sdi_last) begin
            r_state    <= S_IDLE;
            r_last_src <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_load) begin
        r_full      <= 1'b1;
        r_dout      <= w_load_data;
        r_dout_last <= w_load_last;
        r_dout_src  <= w_sdi_xfer;
      end else if (w_drain) begin
        r_full <= 1'b0;
      end
    end
  end

  assign o_pdi_ready  = w_pdi_ready;
  assign o_sdi_ready  = w_sdi_ready;
  assign o_dout       = r_dout;
  assign o_dout_last  = r_dout_last;
  assign o_dout_src   = r_dout_src;
  assign o_dout_valid = r_full;
  assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_friet_lwc_stream_arbiter.sv
// Testbench for friet_lwc_stream_arbiter: cycle vector table, then source drivers
// feeding a word scoreboard for the stall, hold-off and reset sequences.
module tb_friet_lwc_stream_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] i_pdi_data;
  logic         i_pdi_last;
  logic         i_pdi_valid;
  logic         o_pdi_ready;
  logic [W-1:0] i_sdi_data;
  logic         i_sdi_last;
  logic         i_sdi_valid;
  logic         o_sdi_ready;
  logic [W-1:0] o_dout;
  logic         o_dout_last;
  logic         o_dout_src;
  logic         o_dout_valid;
  logic         i_dout_ready;
  logic         o_busy;

  friet_lwc_stream_arbiter #(.G_WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_pdi_data   (i_pdi_data),
    .i_pdi_last   (i_pdi_last),
    .i_pdi_valid  (i_pdi_valid),
    .o_pdi_ready  (o_pdi_ready),
    .i_sdi_data   (i_sdi_data),
    .i_sdi_last   (i_sdi_last),
    .i_sdi_valid  (i_sdi_valid),
    .o_sdi_ready  (o_sdi_ready),
    .o_dout       (o_dout),
    .o_dout_last  (o_dout_last),
    .o_dout_src   (o_dout_src),
    .o_dout_valid (o_dout_valid),
    .i_dout_ready (i_dout_ready),
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
    logic         src;
  } word_t;

  typedef struct {
    logic pv; logic [W-1:0] pd; logic pl;
    logic sv; logic [W-1:0] sd; logic sl;
    logic dr;
    logic ePr; logic eSr; logic eBusy; logic eDv;
    logic chk; logic [W-1:0] eDout; logic eLast; logic eSrc;
  } vec_t;

  localparam logic [W-1:0] A1 = 32'hA000_0001, A2 = 32'hA000_0002, A3 = 32'hA000_0003;
  localparam logic [W-1:0] K1 = 32'h5EC0_0001, K2 = 32'h5EC0_0002, P1 = 32'hB000_0001;

  int    vectorCount = 0;
  int    missCount   = 0;
  bit    autoDrive   = 0;
  bit    monEn       = 0;
  word_t sbQ[$];
  word_t pdiQ[$];
  word_t sdiQ[$];
  vec_t  vecs[14];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectorCount++;
    if (act !== expv) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic timeoutFail(input string name);
    vectorCount++;
    missCount++;
    $display("[TB] FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  task automatic applyStimulus(input vec_t v);
    i_pdi_valid  = v.pv; i_pdi_data = v.pd; i_pdi_last = v.pl;
    i_sdi_valid  = v.sv; i_sdi_data = v.sd; i_sdi_last = v.sl;
    i_dout_ready = v.dr;
  endtask

  function automatic vec_t mkVec(input logic pv, input logic [W-1:0] pd, input logic pl,
                                 input logic sv, input logic [W-1:0] sd, input logic sl,
                                 input logic dr, input logic ePr, input logic eSr,
                                 input logic eBusy, input logic eDv, input logic chk,
                                 input logic [W-1:0] eDout, input logic eLast, input logic eSrc);
    vec_t v;
    v.pv = pv; v.pd = pd; v.pl = pl; v.sv = sv; v.sd = sd; v.sl = sl; v.dr = dr;
    v.ePr = ePr; v.eSr = eSr; v.eBusy = eBusy; v.eDv = eDv;
    v.chk = chk; v.eDout = eDout; v.eLast = eLast; v.eSrc = eSrc;
    return v;
  endfunction

  function automatic word_t mkWord(input logic [W-1:0] d, input logic l, input logic s);
    word_t w;
    w.data = d; w.last = l; w.src = s;
    return w;
  endfunction

  // Each driver presents the head of its queue and retires it after an observed handshake.
  initial begin : pdiDriver
    bit xfer;
    forever begin
      @(negedge clk);
      xfer = i_pdi_valid && o_pdi_ready;
      @(posedge clk);
      #1;
      if (autoDrive) begin
        if (rst) begin
          pdiQ.delete();
          i_pdi_valid = 1'b0;
        end else begin
          if (xfer && pdiQ.size() > 0) void'(pdiQ.pop_front());
          if (pdiQ.size() > 0) begin
            i_pdi_valid = 1'b1; i_pdi_data = pdiQ[0].data; i_pdi_last = pdiQ[0].last;
          end else begin
            i_pdi_valid = 1'b0;
          end
        end
      end
    end
  end

  initial begin : sdiDriver
    bit xfer;
    forever begin
      @(negedge clk);
      xfer = i_sdi_valid && o_sdi_ready;
      @(posedge clk);
      #1;
      if (autoDrive) begin
        if (rst) begin
          sdiQ.delete();
          i_sdi_valid = 1'b0;
        end else begin
          if (xfer && sdiQ.size() > 0) void'(sdiQ.pop_front());
          if (sdiQ.size() > 0) begin
            i_sdi_valid = 1'b1; i_sdi_data = sdiQ[0].data; i_sdi_last = sdiQ[0].last;
          end else begin
            i_sdi_valid = 1'b0;
          end
        end
      end
    end
  end

  initial begin : monitor
    word_t expWord;
    forever begin
      @(negedge clk);
      if (monEn && !rst && o_dout_valid && i_dout_ready) begin
        if (sbQ.size() == 0) begin
          timeoutFail("unexpected output word");
        end else begin
          expWord = sbQ.pop_front();
          checkOutput("drained word {data,last,src}",
                      {30'd0, o_dout, o_dout_last, o_dout_src},
                      {30'd0, expWord.data, expWord.last, expWord.src});
        end
      end
    end
  end

  task automatic waitDrained(input string name, input int maxCycles);
    for (int i = 0; i < maxCycles; i++) begin
      @(negedge clk);
      if (sbQ.size() == 0 && pdiQ.size() == 0 && sdiQ.size() == 0) return;
    end
    timeoutFail(name);
  endtask

  task automatic waitHigh(input string name, input int sel, input int maxCycles);
    for (int i = 0; i < maxCycles; i++) begin
      @(negedge clk);
      if ((sel == 0 && o_dout_valid) || (sel == 1 && o_busy)) return;
    end
    timeoutFail(name);
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    rst = 1'b1;
    i_pdi_valid = 0; i_pdi_data = '0; i_pdi_last = 0;
    i_sdi_valid = 0; i_sdi_data = '0; i_sdi_last = 0;
    i_dout_ready = 0;

    vecs[0]  = mkVec(0, '0, 0, 0, '0, 0, 1,  0, 0, 0, 0,  0, '0, 0, 0);
    vecs[1]  = mkVec(1, A1, 0, 0, '0, 0, 1,  0, 0, 0, 0,  0, '0, 0, 0);
    vecs[2]  = mkVec(1, A1, 0, 0, '0, 0, 1,  1, 0, 1, 0,  0, '0, 0, 0);
    vecs[3]  = mkVec(1, A2, 0, 0, '0, 0, 1,  1, 0, 1, 1,  1, A1, 0, 0);
    vecs[4]  = mkVec(1, A3, 1, 0, '0, 0, 1,  1, 0, 1, 1,  1, A2, 0, 0);
    vecs[5]  = mkVec(0, '0, 0, 0, '0, 0, 0,  0, 0, 0, 1,  1, A3, 1, 0);
    vecs[6]  = mkVec(1, P1, 1, 1, K1, 0, 0,  0, 0, 0, 1,  1, A3, 1, 0);
    vecs[7]  = mkVec(1, P1, 1, 1, K1, 0, 0,  0, 0, 1, 1,  1, A3, 1, 0);
    vecs[8]  = mkVec(1, P1, 1, 1, K1, 0, 1,  0, 1, 1, 1,  1, A3, 1, 0);
    vecs[9]  = mkVec(1, P1, 1, 1, K2, 1, 1,  0, 1, 1, 1,  1, K1, 0, 1);
    vecs[10] = mkVec(1, P1, 1, 0, '0, 0, 1,  0, 0, 0, 1,  1, K2, 1, 1);
    vecs[11] = mkVec(1, P1, 1, 0, '0, 0, 1,  1, 0, 1, 0,  0, '0, 0, 0);
    vecs[12] = mkVec(0, '0, 0, 0, '0, 0, 1,  0, 0, 0, 1,  1, P1, 1, 0);
    vecs[13] = mkVec(0, '0, 0, 0, '0, 0, 1,  0, 0, 0, 0,  0, '0, 0, 0);

    #1;
    checkOutput("reset dout_valid", o_dout_valid, 0);
    checkOutput("reset dout",       o_dout,       0);
    checkOutput("reset dout_last",  o_dout_last,  0);
    checkOutput("reset dout_src",   o_dout_src,   0);
    checkOutput("reset pdi_ready",  o_pdi_ready,  0);
    checkOutput("reset sdi_ready",  o_sdi_ready,  0);
    checkOutput("reset busy",       o_busy,       0);
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;

    $display("[TB] vector table");
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #2;
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("v%0d pdi_ready", i),  o_pdi_ready,  vecs[i].ePr);
      checkOutput($sformatf("v%0d sdi_ready", i),  o_sdi_ready,  vecs[i].eSr);
      checkOutput($sformatf("v%0d busy", i),       o_busy,       vecs[i].eBusy);
      checkOutput($sformatf("v%0d dout_valid", i), o_dout_valid, vecs[i].eDv);
      if (vecs[i].chk) begin
        checkOutput($sformatf("v%0d dout", i),      o_dout,      vecs[i].eDout);
        checkOutput($sformatf("v%0d dout_last", i), o_dout_last, vecs[i].eLast);
        checkOutput($sformatf("v%0d dout_src", i),  o_dout_src,  vecs[i].eSrc);
      end
    end

    $display("[TB] output stall with a full buffer");
    autoDrive = 1; monEn = 1;
    @(posedge clk); #2;
    i_dout_ready = 0;
    for (int i = 1; i <= 4; i++) begin
      pdiQ.push_back(mkWord(32'hC000_0000 + i, (i == 4), 1'b0));
      sbQ.push_back(mkWord(32'hC000_0000 + i, (i == 4), 1'b0));
    end
    waitHigh("stall first word", 0, 10);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      checkOutput("stall pdi_ready",  o_pdi_ready,  0);
      checkOutput("stall dout held",  o_dout,       32'hC000_0001);
      checkOutput("stall dout_valid", o_dout_valid, 1);
    end
    @(posedge clk); #2;
    i_dout_ready = 1;
    @(negedge clk);
    checkOutput("release pdi_ready", o_pdi_ready, 1);
    waitDrained("stall segment drain", 20);

    $display("[TB] sdi held off during a pdi segment");
    @(posedge clk); #2;
    for (int i = 1; i <= 3; i++) begin
      pdiQ.push_back(mkWord(32'hD000_0000 + i, (i == 3), 1'b0));
      sbQ.push_back(mkWord(32'hD000_0000 + i, (i == 3), 1'b0));
    end
    sbQ.push_back(mkWord(32'hE000_0001, 1'b1, 1'b1));
    waitHigh("pdi grant", 1, 10);
    sdiQ.push_back(mkWord(32'hE000_0001, 1'b1, 1'b1));
    begin : holdOff
      bit seenLast;
      seenLast = 0;
      for (int i = 0; i < 10 && !seenLast; i++) begin
        @(negedge clk);
        checkOutput("sdi_ready while pdi granted", o_sdi_ready, 0);
        if (i_pdi_valid && o_pdi_ready && i_pdi_last) seenLast = 1;
      end
      if (!seenLast) timeoutFail("pdi last word");
    end
    @(negedge clk);
    checkOutput("idle bubble busy",      o_busy,      0);
    checkOutput("idle bubble sdi_ready", o_sdi_ready, 0);
    @(negedge clk);
    checkOutput("sdi granted sdi_ready", o_sdi_ready, 1);
    checkOutput("sdi granted pdi_ready", o_pdi_ready, 0);
    waitDrained("holdoff drain", 20);

    $display("[TB] asynchronous reset mid-segment");
    @(posedge clk); #2;
    i_dout_ready = 0;
    pdiQ.push_back(mkWord(32'hF000_0001, 1'b0, 1'b0));
    pdiQ.push_back(mkWord(32'hF000_0002, 1'b1, 1'b0));
    waitHigh("word before reset", 0, 10);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checkOutput("async rst dout_valid", o_dout_valid, 0);
    checkOutput("async rst pdi_ready",  o_pdi_ready,  0);
    checkOutput("async rst sdi_ready",  o_sdi_ready,  0);
    checkOutput("async rst busy",       o_busy,       0);
    sbQ.delete(); pdiQ.delete(); sdiQ.delete();
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;
    i_dout_ready = 1;
    pdiQ.push_back(mkWord(32'h1111_0001, 1'b1, 1'b0));
    sdiQ.push_back(mkWord(32'h2222_0001, 1'b1, 1'b1));
    sbQ.push_back(mkWord(32'h2222_0001, 1'b1, 1'b1));
    sbQ.push_back(mkWord(32'h1111_0001, 1'b1, 1'b0));
    waitHigh("post-reset grant", 1, 10);
    checkOutput("post-reset tie sdi_ready", o_sdi_ready, 1);
    checkOutput("post-reset tie pdi_ready", o_pdi_ready, 0);
    waitDrained("post-reset drain", 20);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
